// File: rtl/cmd_arb_2to1_if.sv
// Command bundle shared by the FMC/UART hosts and the downstream cmd_ncmd_intf.
// sel is a one-cycle request strobe; ack is a one-cycle completion strobe.
interface intf_cmd #(
    parameter int ADDR_BITS = 26,
    parameter int DATA_BITS = 32
);
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 ack;

    modport master (output sel, rd_wr_n, byte_addr, wdata, input rdata, ack);
    modport slave  (input sel, rd_wr_n, byte_addr, wdata, output rdata, ack);
endinterface

// File: rtl/cmd_arb_2to1.sv
// Round-robin 2:1 command arbiter with one pending slot per host and a downstream ack timeout.
// Define CMD_ARB_ERR_RESP_EN to also return an ack with rdata 0xDEADBEEF to the host on timeout.
module cmd_arb_2to1 #(
    parameter int ADDR_BITS              = 26,
    parameter int DATA_BITS              = 32,
    parameter int P_CMD_ACK_TIMEOUT_CLKS = 12
) (
    input  logic    i_sys_clk,
    input  logic    i_sys_rst_n,
    intf_cmd.slave  i_cmd0,
    intf_cmd.slave  i_cmd1,
    intf_cmd.master o_cmd,
    output logic    o_grant,
    output logic    o_timeout
);
    localparam int CNT_W = $clog2(P_CMD_ACK_TIMEOUT_CLKS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);
`ifdef CMD_ARB_ERR_RESP_EN
    localparam logic [DATA_BITS-1:0] ERR_RDATA = DATA_BITS'(32'hDEADBEEF);
`endif

    typedef struct packed {
        logic                 rd_wr_n;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } req_t;

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    logic [1:0]                host_sel;
    req_t [1:0]                host_req;
    logic [1:0]                pend_q;
    req_t [1:0]                slot_q;
    logic [1:0]                slot_clr;

    state_t                    state_q, state_d;
    logic                      grant_q, gnt_d, last_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      do_grant, do_ack, do_to;
    logic                      cmd_sel_q, timeout_q;
    req_t                      cmd_req_q;
    logic [1:0]                ack_q;
    logic [1:0][DATA_BITS-1:0] rdata_q;

    assign host_sel    = {i_cmd1.sel, i_cmd0.sel};
    assign host_req[0] = {i_cmd0.rd_wr_n, i_cmd0.byte_addr, i_cmd0.wdata};
    assign host_req[1] = {i_cmd1.rd_wr_n, i_cmd1.byte_addr, i_cmd1.wdata};

    // A slot accepts a new sel when empty or on the very edge it is being retired.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            pend_q <= '0;
            slot_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (host_sel[p] && (!pend_q[p] || slot_clr[p])) begin
                    pend_q[p] <= 1'b1;
                    slot_q[p] <= host_req[p];
                end else if (slot_clr[p]) begin
                    pend_q[p] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = grant_q;
        do_grant = 1'b0;
        do_ack   = 1'b0;
        do_to    = 1'b0;
        slot_clr = '0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    do_grant = 1'b1;
                    gnt_d    = (&pend_q) ? ~last_q : pend_q[1];
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // ack on the final count wins over the timeout
                if (o_cmd.ack) begin
                    do_ack            = 1'b1;
                    slot_clr[grant_q] = 1'b1;
                    state_d           = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    do_to             = 1'b1;
                    slot_clr[grant_q] = 1'b1;
                    state_d           = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            cmd_sel_q <= 1'b0;
            cmd_req_q <= '0;
            timeout_q <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_sel_q <= do_grant;
            timeout_q <= do_to;
            ack_q     <= '0;
            if (do_grant) begin
                grant_q   <= gnt_d;
                last_q    <= gnt_d;
                cnt_q     <= '0;
                cmd_req_q <= slot_q[gnt_d];
            end else if (state_q == WAIT_ACK) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (do_ack) begin
                ack_q[grant_q]   <= 1'b1;
                rdata_q[grant_q] <= o_cmd.rdata;
            end
`ifdef CMD_ARB_ERR_RESP_EN
            else if (do_to) begin
                ack_q[grant_q]   <= 1'b1;
                rdata_q[grant_q] <= ERR_RDATA;
            end
`endif
        end
    end

    assign o_cmd.sel       = cmd_sel_q;
    assign o_cmd.rd_wr_n   = cmd_req_q.rd_wr_n;
    assign o_cmd.byte_addr = cmd_req_q.addr;
    assign o_cmd.wdata     = cmd_req_q.wdata;
    assign i_cmd0.ack      = ack_q[0];
    assign i_cmd0.rdata    = rdata_q[0];
    assign i_cmd1.ack      = ack_q[1];
    assign i_cmd1.rdata    = rdata_q[1];
    assign o_grant         = grant_q;
    assign o_timeout       = timeout_q;
endmodule

// File: tb/tb_cmd_arb_2to1.sv
// Directed bench for cmd_arb_2to1: latency, round-robin order, timeout boundary, reset abort.
module tb_cmd_arb_2to1;
    logic clk = 1'b0;
    logic rst_n;
    logic grant, timeout;
    int   n_chk = 0;
    int   n_err = 0;

    intf_cmd #(.ADDR_BITS(26), .DATA_BITS(32)) cmd0 ();
    intf_cmd #(.ADDR_BITS(26), .DATA_BITS(32)) cmd1 ();
    intf_cmd #(.ADDR_BITS(26), .DATA_BITS(32)) dcmd ();

    cmd_arb_2to1 dut (
        .i_sys_clk  (clk),
        .i_sys_rst_n(rst_n),
        .i_cmd0     (cmd0),
        .i_cmd1     (cmd1),
        .o_cmd      (dcmd),
        .o_grant    (grant),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the downstream strobe, ack one cycle later, optionally re-request on the ack cycle.
    task automatic serve(input logic g, input logic [25:0] a, input logic [31:0] rd,
                         input logic rs_en, input logic rs_port, input logic [25:0] rs_addr);
        int k = 0;
        while (dcmd.sel !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("serve_sel_seen", dcmd.sel, 1);
        chk("serve_grant", grant, g);
        chk("serve_addr", dcmd.byte_addr, a);
        tick();
        dcmd.ack   = 1'b1;
        dcmd.rdata = rd;
        if (rs_en) begin
            if (rs_port) begin cmd1.sel = 1'b1; cmd1.byte_addr = rs_addr; end
            else         begin cmd0.sel = 1'b1; cmd0.byte_addr = rs_addr; end
        end
        tick();
        dcmd.ack = 1'b0;
        cmd0.sel = 1'b0;
        cmd1.sel = 1'b0;
        if (g) begin
            chk("serve_ack1", cmd1.ack, 1);
            chk("serve_ack0_idle", cmd0.ack, 0);
            chk("serve_rdata1", cmd1.rdata, rd);
        end else begin
            chk("serve_ack0", cmd0.ack, 1);
            chk("serve_ack1_idle", cmd1.ack, 0);
            chk("serve_rdata0", cmd0.rdata, rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd0.sel = 0; cmd0.rd_wr_n = 0; cmd0.byte_addr = 0; cmd0.wdata = 0;
        cmd1.sel = 0; cmd1.rd_wr_n = 0; cmd1.byte_addr = 0; cmd1.wdata = 0;
        dcmd.ack = 0; dcmd.rdata = 0;
        repeat (3) tick();
        chk("rst_sel", dcmd.sel, 0);
        chk("rst_ack0", cmd0.ack, 0);
        chk("rst_ack1", cmd1.ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_addr", dcmd.byte_addr, 0);
        rst_n = 1'b1;
        tick();

        // single read on port 0, ack 3 cycles after sel
        cmd0.sel = 1; cmd0.rd_wr_n = 1; cmd0.byte_addr = 26'h100;
        tick();
        cmd0.sel = 0;
        chk("lat_not_yet", dcmd.sel, 0);
        tick();
        chk("lat_sel", dcmd.sel, 1);
        chk("lat_addr", dcmd.byte_addr, 26'h100);
        chk("lat_rdwr", dcmd.rd_wr_n, 1);
        chk("lat_grant", grant, 0);
        tick();
        chk("sel_one_cycle", dcmd.sel, 0);
        tick();
        chk("addr_stable", dcmd.byte_addr, 26'h100);
        tick();
        dcmd.ack = 1; dcmd.rdata = 32'h1234;
        tick();
        dcmd.ack = 0;
        chk("rd_ack0", cmd0.ack, 1);
        chk("rd_rdata0", cmd0.rdata, 32'h1234);
        chk("rd_ack1", cmd1.ack, 0);
        chk("rd_timeout", timeout, 0);
        chk("rd_grant", grant, 0);
        tick();
        chk("rd_ack0_pulse", cmd0.ack, 0);
        chk("rd_rdata_hold", cmd0.rdata, 32'h1234);

        // reset, then both ports request on one edge
        rst_n = 0;
        #1;
        chk("async_rst_rdata", cmd0.rdata, 0);
        tick();
        rst_n = 1;
        tick();
        cmd0.sel = 1; cmd0.byte_addr = 26'h200;
        cmd1.sel = 1; cmd1.byte_addr = 26'h300;
        tick();
        cmd0.sel = 0; cmd1.sel = 0;
        serve(0, 26'h200, 32'hA0, 0, 0, 0);
        serve(1, 26'h300, 32'hB0, 0, 0, 0);

        // port 0 back-to-back against pending port 1: 0,1,0,0
        cmd0.sel = 1; cmd0.byte_addr = 26'h10;
        cmd1.sel = 1; cmd1.byte_addr = 26'h20;
        tick();
        cmd0.sel = 0; cmd1.sel = 0;
        serve(0, 26'h10, 32'h1010, 1, 0, 26'h11);
        cmd0.sel = 1; cmd0.byte_addr = 26'h99;  // slot full: must be ignored
        tick();
        cmd0.sel = 0;
        serve(1, 26'h20, 32'h2222, 0, 0, 0);
        serve(0, 26'h11, 32'h1111, 1, 0, 26'h12);
        serve(0, 26'h12, 32'h1212, 0, 0, 0);

        // timeout with no downstream ack
        cmd1.sel = 1; cmd1.byte_addr = 26'h40;
        tick();
        cmd1.sel = 0;
        tick();
        chk("to_sel", dcmd.sel, 1);
        chk("to_grant", grant, 1);
        repeat (11) tick();
        chk("to_not_early", timeout, 0);
        tick();
        chk("to_pulse", timeout, 1);
`ifdef CMD_ARB_ERR_RESP_EN
        chk("to_ack1", cmd1.ack, 1);
        chk("to_rdata1", cmd1.rdata, 32'hDEADBEEF);
`else
        chk("to_ack1", cmd1.ack, 0);
        chk("to_rdata1", cmd1.rdata, 32'h2222);
`endif
        chk("to_ack0", cmd0.ack, 0);
        tick();
        chk("to_pulse_end", timeout, 0);
        chk("to_ack1_end", cmd1.ack, 0);
        tick();
        chk("to_slot_cleared", dcmd.sel, 0);

        // ack on the final timeout count wins
        cmd0.sel = 1; cmd0.byte_addr = 26'h50;
        tick();
        cmd0.sel = 0;
        tick();
        chk("edge_sel", dcmd.sel, 1);
        repeat (11) tick();
        dcmd.ack = 1; dcmd.rdata = 32'h5555;
        tick();
        dcmd.ack = 0;
        chk("edge_ack0", cmd0.ack, 1);
        chk("edge_rdata0", cmd0.rdata, 32'h5555);
        chk("edge_no_to", timeout, 0);
        tick();
        chk("edge_no_to_late", timeout, 0);

        // stray ack while idle
        dcmd.ack = 1; dcmd.rdata = 32'h7777;
        tick();
        dcmd.ack = 0;
        chk("stray_ack0", cmd0.ack, 0);
        chk("stray_ack1", cmd1.ack, 0);
        chk("stray_sel", dcmd.sel, 0);
        chk("stray_rdata0", cmd0.rdata, 32'h5555);

        // reset during WAIT_ACK, late ack after release
        cmd0.sel = 1; cmd0.byte_addr = 26'h60;
        tick();
        cmd0.sel = 0;
        tick();
        chk("abort_sel", dcmd.sel, 1);
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("abort_addr_async", dcmd.byte_addr, 0);
        tick();
        rst_n = 1;
        dcmd.ack = 1; dcmd.rdata = 32'h8888;
        tick();
        dcmd.ack = 0;
        chk("abort_ack0", cmd0.ack, 0);
        chk("abort_ack1", cmd1.ack, 0);
        chk("abort_rdata0", cmd0.rdata, 0);
        tick();
        tick();
        chk("abort_slots_empty", dcmd.sel, 0);
        cmd0.sel = 1; cmd0.byte_addr = 26'h70;
        cmd1.sel = 1; cmd1.byte_addr = 26'h80;
        tick();
        cmd0.sel = 0; cmd1.sel = 0;
        serve(0, 26'h70, 32'h7070, 0, 0, 0);
        serve(1, 26'h80, 32'h8080, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cmd_arb_2to1.md
CMD_ARB_2TO1 -- requirements
Module: cmd_arb_2to1

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 26, command byte-address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, command wdata/rdata width.
REQ-003 SHALL have parameter P_CMD_ACK_TIMEOUT_CLKS, default 12, cycles to wait for downstream ack; must be less than the ack timeout of either host.
REQ-004 SHALL have port i_sys_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_cmd0, intf_cmd.slave, bundle: host 0 (FMC). Inputs sel, rd_wr_n, byte_addr[ADDR_BITS], wdata[DATA_BITS]; outputs rdata[DATA_BITS], ack.
REQ-007 SHALL have port i_cmd1, intf_cmd.slave, bundle: host 1 (debug UART); same members as i_cmd0.
REQ-008 SHALL have port o_cmd, intf_cmd.master, bundle: merged command to the downstream cmd_ncmd_intf.
REQ-009 SHALL have port o_grant, output, 1 bit: index of the port currently or last granted.
REQ-010 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a downstream ack timeout occurs.

Function
REQ-011 SHALL treat sel on each port as a one-cycle request pulse and latch rd_wr_n, byte_addr and wdata into that port's pending slot at that edge.
REQ-012 SHALL ignore a sel on a port whose slot is already pending; the stored request is not overwritten.
REQ-013 SHALL implement FSM states IDLE and WAIT_ACK; the reset state is IDLE.
REQ-014 In IDLE with at least one pending slot, SHALL at the next edge grant one port, drive o_cmd.sel high for exactly one cycle with that slot's fields, set o_grant, and enter WAIT_ACK.
REQ-015 Arbitration SHALL be round-robin: with both slots pending, grant the port not last granted; with one slot pending, grant that port.
REQ-016 Latency: a host sel sampled at edge E0 SHALL yield o_cmd.sel high in the cycle after E1 when the arbiter is idle.
REQ-017 o_cmd.rd_wr_n, byte_addr and wdata SHALL stay stable from the sel cycle until the FSM leaves WAIT_ACK.
REQ-018 In WAIT_ACK, o_cmd.ack sampled high SHALL drive the granted port's ack high for exactly one cycle next cycle, with rdata equal to the sampled o_cmd.rdata.
REQ-019 On that same edge, the FSM SHALL clear the granted port's slot and return to IDLE; the next grant can follow one cycle later.
REQ-020 The non-granted port's ack SHALL be 0 at all times; rdata of each port SHALL hold its last returned value.
REQ-021 The timeout counter SHALL clear on entry to WAIT_ACK and increment every WAIT_ACK cycle; width is $clog2(P_CMD_ACK_TIMEOUT_CLKS)+1.
REQ-022 If no ack arrives by count P_CMD_ACK_TIMEOUT_CLKS-1, SHALL pulse o_timeout for one cycle, clear the granted slot, and return to IDLE.
REQ-023 An ack on the same cycle as the final timeout count SHALL take precedence; it is treated as a normal ack with no o_timeout.
REQ-024 o_cmd.ack while in IDLE (stray or late) SHALL be ignored.
REQ-025 A new sel on the granted port on the same edge its slot clears SHALL be latched as a new pending request.

Reset
REQ-026 Asserting i_sys_rst_n low SHALL immediately force state IDLE, clear both slots, and set o_cmd.sel, both acks, o_timeout and the counter to 0.
REQ-027 Reset SHALL force o_grant to 0, the round-robin pointer to "last granted = 1", and all rdata, byte_addr and wdata to 0.
REQ-028 Reset mid-transaction SHALL drop the in-flight command with no ack to any host.

Configuration
REQ-029 With macro CMD_ARB_ERR_RESP_EN defined, a timeout SHALL also pulse ack to the granted port for one cycle with rdata = 32'hDEADBEEF (zero-extended or truncated to DATA_BITS).
REQ-030 Without CMD_ARB_ERR_RESP_EN, a timeout SHALL return no ack; the host relies on its own timeout.

Verification
REQ-031 Single read on port 0, downstream ack 3 cycles after sel with rdata=0x1234 -> i_cmd0.ack one cycle, rdata=0x1234, o_grant=0, o_timeout=0.
REQ-032 Both ports sel on the same edge after reset -> port 0 is served first, then port 1; o_cmd.sel pulses twice with the matching addresses.
REQ-033 Port 0 issues 3 back-to-back requests while port 1 is pending -> grants alternate 0,1,0,0.
REQ-034 No downstream ack, P_CMD_ACK_TIMEOUT_CLKS=12 -> o_timeout pulses 12 cycles after o_cmd.sel; no host ack (macro off) or ack with 0xDEADBEEF (macro on).
REQ-035 Downstream ack on the exact final timeout cycle -> normal ack, o_timeout stays 0; a stray ack injected in IDLE -> no host ack.
REQ-036 i_sys_rst_n asserted during WAIT_ACK and a late downstream ack after release -> no host ack, both slots empty, next request is granted to port 0.
